// File: rtl/params_noc.sv
// ============================================================================
// params_noc : shared router parameters and the encoded port field
// Rev 1.0
// ============================================================================
`default_nettype none

package params_noc;

   localparam int PORT_NUM = 5;
   localparam int VC_NUM   = 2;
   localparam int PORT_W   = $clog2(PORT_NUM);

   typedef enum logic [2:0] {
      LOCAL = 3'd0,
      NORTH = 3'd1,
      SOUTH = 3'd2,
      EAST  = 3'd3,
      WEST  = 3'd4
   } inout_Port;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter : combinational round-robin pick, highest priority at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   int w_best_i;
   int w_best_d;
   int w_d;

   // The winner is the requester at the smallest circular distance from ptr.
   always_comb begin
      w_best_i = 0;
      w_best_d = N;
      w_d      = 0;
      gnt      = '0;
      for (int i = 0; i < N; i++) begin
         w_d = (i + N - int'(ptr)) % N;
         if (req[i] && (w_d < w_best_d)) begin
            w_best_d = w_d;
            w_best_i = i;
         end
      end
      any = (w_best_d < N);
      idx = IDX_W'(w_best_i);
      for (int i = 0; i < N; i++) begin
         gnt[i] = any && (w_best_i == i);
      end
   end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
// ============================================================================
// switch_allocator : separable input-first round-robin switch allocator
// Rev 1.0
// ============================================================================
`default_nettype none

module switch_allocator
   import params_noc::*;
#(
   parameter int PORT_NUM = params_noc::PORT_NUM,
   parameter int VC_NUM   = params_noc::VC_NUM,
   parameter int PORT_W   = params_noc::PORT_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORT_NUM*VC_NUM-1:0]    switch_Req_i,
   input  logic [PORT_NUM*VC_NUM*PORT_W-1:0] out_Port_i,
   input  logic [PORT_NUM-1:0]           out_Ready_i,
   output logic [PORT_NUM*VC_NUM-1:0]    grant_o,
   output logic [PORT_NUM*PORT_W-1:0]    xbar_Sel_o,
   output logic [PORT_NUM-1:0]           xbar_Val_o,
   output logic                          err_o
);

   localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

   logic [VC_W-1:0]            r_in_ptr  [PORT_NUM];
   logic [PORT_W-1:0]          r_out_ptr [PORT_NUM];

   logic [PORT_NUM*VC_NUM-1:0] w_elig;
   logic                       w_bad;
   logic [PORT_W-1:0]          w_code;

   logic [VC_NUM-1:0]          w_s1_gnt  [PORT_NUM];
   logic [VC_W-1:0]            w_s1_idx  [PORT_NUM];
   logic [PORT_NUM-1:0]        w_s1_any;
   logic [PORT_W-1:0]          w_cand    [PORT_NUM];

   logic [PORT_NUM-1:0]        w_s2_req  [PORT_NUM];
   logic [PORT_NUM-1:0]        w_s2_gnt  [PORT_NUM];
   logic [PORT_W-1:0]          w_s2_idx  [PORT_NUM];
   logic [PORT_NUM-1:0]        w_s2_any;

   logic [PORT_NUM-1:0]        w_won;
   logic [PORT_NUM*VC_NUM-1:0] w_grant;

   // Requests naming a port outside the router are dropped and flagged.
   always_comb begin
      w_elig = '0;
      w_bad  = 1'b0;
      w_code = '0;
      for (int r = 0; r < PORT_NUM*VC_NUM; r++) begin
         w_code = out_Port_i[r*PORT_W +: PORT_W];
         if (switch_Req_i[r]) begin
            if (int'(w_code) < PORT_NUM) begin
               w_elig[r] = out_Ready_i[w_code];
            end else begin
               w_bad = 1'b1;
            end
         end
      end
   end

   generate
      for (genvar p = 0; p < PORT_NUM; p++) begin : g_stage1
         rr_arbiter #(
            .N     (VC_NUM),
            .IDX_W (VC_W)
         ) u_in_arb (
            .req (w_elig[p*VC_NUM +: VC_NUM]),
            .ptr (r_in_ptr[p]),
            .gnt (w_s1_gnt[p]),
            .idx (w_s1_idx[p]),
            .any (w_s1_any[p])
         );
      end
   endgenerate

   always_comb begin
      for (int p = 0; p < PORT_NUM; p++) begin
         w_cand[p] = '0;
         for (int v = 0; v < VC_NUM; v++) begin
            if (int'(w_s1_idx[p]) == v) begin
               w_cand[p] = out_Port_i[(p*VC_NUM+v)*PORT_W +: PORT_W];
            end
         end
      end
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int p = 0; p < PORT_NUM; p++) begin
            w_s2_req[o][p] = w_s1_any[p] && (int'(w_cand[p]) == o);
         end
      end
   end

   generate
      for (genvar o = 0; o < PORT_NUM; o++) begin : g_stage2
         rr_arbiter #(
            .N     (PORT_NUM),
            .IDX_W (PORT_W)
         ) u_out_arb (
            .req (w_s2_req[o]),
            .ptr (r_out_ptr[o]),
            .gnt (w_s2_gnt[o]),
            .idx (w_s2_idx[o]),
            .any (w_s2_any[o])
         );
      end
   endgenerate

   // An input is granted only if its stage-1 candidate also wins its output.
   always_comb begin
      w_won   = '0;
      w_grant = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         w_won = w_won | w_s2_gnt[o];
      end
      for (int p = 0; p < PORT_NUM; p++) begin
         w_grant[p*VC_NUM +: VC_NUM] = w_won[p] ? w_s1_gnt[p] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_o    <= '0;
         xbar_Sel_o <= '0;
         xbar_Val_o <= '0;
         err_o      <= 1'b0;
         for (int p = 0; p < PORT_NUM; p++) begin
            r_in_ptr[p]  <= '0;
            r_out_ptr[p] <= '0;
         end
      end else begin
         grant_o    <= w_grant;
         xbar_Val_o <= w_s2_any;
         err_o      <= w_bad;
         for (int o = 0; o < PORT_NUM; o++) begin
            xbar_Sel_o[o*PORT_W +: PORT_W] <= w_s2_any[o] ? w_s2_idx[o] : '0;
            if (w_s2_any[o]) begin
               r_out_ptr[o] <= (int'(w_s2_idx[o]) == PORT_NUM-1) ? '0 : w_s2_idx[o] + 1'b1;
            end
         end
         for (int p = 0; p < PORT_NUM; p++) begin
            if (w_won[p]) begin
               r_in_ptr[p] <= (int'(w_s1_idx[p]) == VC_NUM-1) ? '0 : w_s1_idx[p] + 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_switch_allocator.sv
// ============================================================================
// tb_switch_allocator : directed self-checking bench for switch_allocator
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_switch_allocator;

   localparam int P  = 5;
   localparam int V  = 2;
   localparam int PW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [P*V-1:0]    switch_Req_i;
   logic [P*V*PW-1:0] out_Port_i;
   logic [P-1:0]      out_Ready_i;
   logic [P*V-1:0]    grant_o;
   logic [P*PW-1:0]   xbar_Sel_o;
   logic [P-1:0]      xbar_Val_o;
   logic              err_o;

   int n_cmp = 0;
   int n_bad = 0;

   switch_allocator dut (
      .clk          (clk),
      .rst          (rst),
      .switch_Req_i (switch_Req_i),
      .out_Port_i   (out_Port_i),
      .out_Ready_i  (out_Ready_i),
      .grant_o      (grant_o),
      .xbar_Sel_o   (xbar_Sel_o),
      .xbar_Val_o   (xbar_Val_o),
      .err_o        (err_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input int v, input int port);
      switch_Req_i[p*V+v]           = 1'b1;
      out_Port_i[(p*V+v)*PW +: PW]  = 3'(port);
   endtask

   task automatic clr_all();
      switch_Req_i = '0;
      out_Port_i   = '0;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] sel(input int o);
      logic [P*PW-1:0] s;
      s = xbar_Sel_o;
      return s[o*PW +: PW];
   endfunction

   initial begin
      int exp_bits [10];
      exp_bits = '{1, 3, 5, 7, 8, 0, 2, 4, 6, 9};

      // Reset with a live request pending
      rst = 1'b1;
      out_Ready_i = '1;
      clr_all();
      set_req(0, 1, 3);
      step();
      check("rst_grant",   32'(grant_o),    32'h0);
      check("rst_val",     32'(xbar_Val_o), 32'h0);
      check("rst_err",     32'(err_o),      32'h0);
      step();
      check("rst2_grant",  32'(grant_o),    32'h0);
      check("rst2_sel",    32'(xbar_Sel_o), 32'h0);
      rst = 1'b0;
      step();
      check("first_grant", 32'(grant_o),    32'h2);
      check("first_val",   32'(xbar_Val_o), 32'h08);
      check("first_sel3",  32'(sel(3)),     32'h0);
      clr_all();
      step();
      check("idle_grant",  32'(grant_o),    32'h0);
      check("idle_val",    32'(xbar_Val_o), 32'h0);

      // Output conflict: in1 and in2 alternate on port 4
      set_req(1, 0, 4);
      set_req(2, 0, 4);
      for (int k = 0; k < 4; k++) begin
         step();
         check("conf_grant", 32'(grant_o),    (k % 2 == 0) ? 32'h004 : 32'h010);
         check("conf_sel4",  32'(sel(4)),     (k % 2 == 0) ? 32'd1 : 32'd2);
         check("conf_val",   32'(xbar_Val_o), 32'h10);
      end
      clr_all();
      step();

      // VC fairness on input 0
      set_req(0, 0, 1);
      set_req(0, 1, 2);
      for (int k = 0; k < 4; k++) begin
         step();
         check("vc_grant", 32'(grant_o),    (k % 2 == 0) ? 32'h1 : 32'h2);
         check("vc_val",   32'(xbar_Val_o), (k % 2 == 0) ? 32'h02 : 32'h04);
      end
      clr_all();
      step();

      // Backpressure on port 2 leaves only in3 vc1 eligible
      out_Ready_i = 5'b11011;
      set_req(3, 0, 2);
      set_req(3, 1, 1);
      for (int k = 0; k < 2; k++) begin
         step();
         check("bp_grant", 32'(grant_o), 32'h080);
         check("bp_sel1",  32'(sel(1)),  32'd3);
      end
      out_Ready_i = '1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("bp_rr_grant", 32'(grant_o), (k % 2 == 0) ? 32'h040 : 32'h080);
      end
      clr_all();
      step();

      // Out-of-range code next to a valid request
      set_req(4, 0, 6);
      set_req(0, 0, 3);
      step();
      check("err_pulse", 32'(err_o),      32'h1);
      check("err_grant", 32'(grant_o),    32'h001);
      check("err_val",   32'(xbar_Val_o), 32'h08);
      clr_all();
      step();
      check("err_clear", 32'(err_o),      32'h0);
      set_req(4, 0, 7);
      set_req(4, 1, 5);
      step();
      check("err_multi",       32'(err_o),   32'h1);
      check("err_multi_grant", 32'(grant_o), 32'h0);
      clr_all();
      step();
      check("err_multi_clear", 32'(err_o),   32'h0);

      // Full load onto port 0, each requester drops on its grant
      for (int p = 0; p < P; p++) begin
         for (int v = 0; v < V; v++) begin
            set_req(p, v, 0);
         end
      end
      for (int k = 0; k < 10; k++) begin
         step();
         check("full_grant", 32'(grant_o),    32'(1) << exp_bits[k]);
         check("full_sel0",  32'(sel(0)),     32'(exp_bits[k] / V));
         check("full_val",   32'(xbar_Val_o), 32'h01);
         switch_Req_i = switch_Req_i & ~grant_o;
      end
      step();
      check("full_idle_grant", 32'(grant_o),    32'h0);
      check("full_idle_val",   32'(xbar_Val_o), 32'h0);

      // Reset mid-operation discards the pending request's allocation
      set_req(2, 1, 3);
      rst = 1'b1;
      step();
      check("mid_rst_grant", 32'(grant_o),    32'h0);
      check("mid_rst_val",   32'(xbar_Val_o), 32'h0);
      rst = 1'b0;
      step();
      check("post_rst_grant", 32'(grant_o), 32'h020);
      check("post_rst_sel3",  32'(sel(3)),  32'd2);
      clr_all();
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
